// File: rtl/dcache_pkg.sv
// Shared state type and line-geometry constants for the write-through
// data-cache miss/store controller.
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REFILL,
    ST_COMMIT,
    ST_STORE,
    ST_RELEASE
  } dcache_state_t;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_WORDS_PER_LINE = 4;

  function automatic int unsigned line_off_w(input int unsigned words,
                                             input int unsigned dw);
    return $clog2(words * (dw / 8));
  endfunction

  function automatic int unsigned word_idx_w(input int unsigned words);
    return $clog2(words);
  endfunction

  localparam int unsigned LINE_OFF_W = line_off_w(DEF_WORDS_PER_LINE, DEF_DATA_WIDTH);
  localparam int unsigned WORD_IDX_W = word_idx_w(DEF_WORDS_PER_LINE);

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Memory-stage miss/store controller: load misses become line refills,
// stores become posted write-through requests; stallmem freezes the pipe.
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              memreadm,
  input  logic                              memwritem,
  input  logic                              hitm,
  input  logic [ADDR_WIDTH-1:0]             addrm,
  input  logic [DATA_WIDTH-1:0]             writedatam,
  output logic                              stallmem,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_ack,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              fill_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word_idx,
  output logic [DATA_WIDTH-1:0]             fill_data,
  output logic                              fill_tag_we
);

  localparam int unsigned IDX_W  = word_idx_w(WORDS_PER_LINE);
  localparam int unsigned OFF_W  = line_off_w(WORDS_PER_LINE, DATA_WIDTH);
  localparam int unsigned BYTE_W = $clog2(DATA_WIDTH / 8);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = {ADDR_WIDTH{1'b1}} << BYTE_W;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = {ADDR_WIDTH{1'b1}} << OFF_W;
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(WORDS_PER_LINE - 1);

  dcache_state_t           state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // A store wins over a simultaneous load; no write-allocate.
        if (memwritem) begin
          state_d     = ST_STORE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addrm & WORD_MASK;
          mem_wdata_d = writedatam;
        end else if (memreadm && !hitm) begin
          state_d    = ST_REFILL;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addrm & LINE_MASK;
          cnt_d      = '0;
        end
      end

      ST_REFILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d   = ST_COMMIT;
            mem_req_d = 1'b0;
          end else begin
            // Address held as a running pointer: equals base + cnt*word_bytes.
            mem_addr_d = mem_addr_q + WORD_BYTES;
          end
        end
      end

      ST_COMMIT: state_d = ST_IDLE;

      ST_STORE: begin
        if (mem_ack) begin
          state_d   = ST_RELEASE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end

      ST_RELEASE: state_d = ST_IDLE;

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

  assign fill_we       = (state_q == ST_REFILL) && mem_ack;
  assign fill_word_idx = cnt_q;
  assign fill_data     = mem_rdata;
  assign fill_tag_we   = (state_q == ST_COMMIT);

  // RELEASE deliberately ignores memwritem so the store is not reissued.
  assign stallmem = ((state_q != ST_IDLE) && (state_q != ST_RELEASE)) ||
                    ((state_q == ST_IDLE) && (memwritem || (memreadm && !hitm)));

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: table ops, random ops against
// a transaction-level cache/memory model, and a reset-during-refill sequence.
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memreadm, memwritem, hitm;
  logic [31:0] addrm, writedatam;
  logic        stallmem, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [1:0]  fill_word_idx;
  logic [31:0] fill_data;
  logic        fill_tag_we;

  int checks = 0;
  int errors = 0;

  bit          line_valid[logic [31:0]];
  logic [31:0] memory[logic [31:0]];

  typedef struct {
    int          kind;      // 0 load, 1 store, 2 load+store together
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    int          exp_stall;
    int          exp_reqs;
  } vec_t;

  vec_t vecs[8];

  dcache_refill_ctrl #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .WORDS_PER_LINE(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memreadm     (memreadm),
    .memwritem    (memwritem),
    .hitm         (hitm),
    .addrm        (addrm),
    .writedatam   (writedatam),
    .stallmem     (stallmem),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .fill_we      (fill_we),
    .fill_word_idx(fill_word_idx),
    .fill_data    (fill_data),
    .fill_tag_we  (fill_tag_we)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] wa);
    if (memory.exists(wa)) return memory[wa];
    return {wa[15:0], ~wa[15:0]};
  endfunction

  // Runs one memory-stage instruction to completion and compares what the
  // controller did with what the cache/memory model says must happen.
  task automatic run_op(input string name, input int kind, input logic [31:0] a,
                        input logic [31:0] d, input int waits,
                        input int tbl_stall, input int tbl_reqs);
    logic [31:0] base, waddr;
    bit          was_hit;
    int e_stall, e_reqs, e_fills, e_tags;
    int stall_n, req_n, fill_n, tag_n, bad, extra, k, wcnt, cyc;
    bit done;
    base    = a & ~32'hF;
    waddr   = a & ~32'h3;
    was_hit = line_valid.exists(base);
    if (kind != 0) begin
      e_stall = waits + 2; e_reqs = 1; e_fills = 0; e_tags = 0;
    end else if (was_hit) begin
      e_stall = 0; e_reqs = 0; e_fills = 0; e_tags = 0;
    end else begin
      e_stall = 4 * (waits + 1) + 2; e_reqs = 4; e_fills = 4; e_tags = 1;
    end
    stall_n = 0; req_n = 0; fill_n = 0; tag_n = 0; bad = 0; extra = 0;
    k = 0; wcnt = 0; cyc = 0; done = 0;
    memreadm   = (kind != 1);
    memwritem  = (kind != 0);
    addrm      = a;
    writedatam = d;
    while (!done && cyc < 200) begin
      hitm      = line_valid.exists(base);
      mem_ack   = mem_req && (wcnt == waits);
      mem_rdata = mem_read(mem_addr);
      @(negedge clk);
      if (stallmem) stall_n++; else done = 1;
      if (mem_req) begin
        if (kind == 0) begin
          if (mem_addr != base + 32'(4 * k) || mem_we) bad++;
        end else begin
          if (mem_addr != waddr || !mem_we || mem_wdata != d) bad++;
        end
      end
      if (fill_we) begin
        if (kind != 0 || fill_word_idx != 2'(k) || fill_data != mem_read(base + 32'(4 * k)))
          bad++;
        fill_n++;
      end
      if (mem_req) begin
        if (mem_ack) begin
          req_n++;
          wcnt = 0;
          if (kind != 0) memory[waddr] = d;
          else k++;
        end else begin
          wcnt++;
        end
      end
      if (fill_tag_we) begin
        tag_n++;
        line_valid[base] = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " timeout"}, done, 1);
    // Idle afterwards with a stray ack: nothing may start or be written.
    memreadm  = 1'b0;
    memwritem = 1'b0;
    mem_ack   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (mem_req || fill_we || fill_tag_we || stallmem) extra++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    check({name, " stall"}, stall_n, e_stall);
    check({name, " reqs"},  req_n,   e_reqs);
    check({name, " fills"}, fill_n,  e_fills);
    check({name, " tags"},  tag_n,   e_tags);
    check({name, " content"}, bad,   0);
    check({name, " after"}, extra,   0);
    if (tbl_stall >= 0) check({name, " tbl_stall"}, stall_n, tbl_stall);
    if (tbl_reqs >= 0)  check({name, " tbl_reqs"},  req_n,   tbl_reqs);
  endtask

  initial begin
    int fills_seen;
    int cyc;

    vecs[0] = '{0, 32'h0000_1034, 32'h0,         0, 6,  4};
    vecs[1] = '{0, 32'h0000_1038, 32'h0,         0, 0,  0};
    vecs[2] = '{0, 32'h0000_5034, 32'h0,         3, 18, 4};
    vecs[3] = '{1, 32'h0000_2000, 32'hDEADBEEF,  2, 4,  1};
    vecs[4] = '{2, 32'h0000_4012, 32'h1234_5678, 0, 2,  1};
    vecs[5] = '{0, 32'h0000_4010, 32'h0,         1, 10, 4};
    vecs[6] = '{0, 32'h0000_2004, 32'h0,         0, 6,  4};
    vecs[7] = '{1, 32'h0000_1030, 32'hCAFE_F00D, 0, 2,  1};

    rst_n      = 1'b0;
    memreadm   = 1'b0;
    memwritem  = 1'b0;
    hitm       = 1'b0;
    addrm      = '0;
    writedatam = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_req",     mem_req,     0);
    check("rst mem_we",      mem_we,      0);
    check("rst mem_addr",    mem_addr,    0);
    check("rst mem_wdata",   mem_wdata,   0);
    check("rst fill_we",     fill_we,     0);
    check("rst fill_tag_we", fill_tag_we, 0);
    check("rst stall idle",  stallmem,    0);
    memreadm = 1'b1;
    #1;
    check("rst stall miss",  stallmem,    1);
    memreadm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].kind, vecs[i].addr, vecs[i].data,
             vecs[i].waits, vecs[i].exp_stall, vecs[i].exp_reqs);

    for (int i = 0; i < 24; i++) begin
      int          kind;
      logic [31:0] a;
      kind = ($urandom_range(0, 9) < 6) ? 0 : (($urandom_range(0, 3) == 0) ? 2 : 1);
      a    = 32'h0000_8000 + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", i), kind, a, $urandom, $urandom_range(0, 3), -1, -1);
    end

    // Reset asserted mid-refill after two words have been written.
    memreadm  = 1'b1;
    memwritem = 1'b0;
    addrm     = 32'h0000_6034;
    fills_seen = 0;
    cyc = 0;
    while (fills_seen < 2 && cyc < 20) begin
      hitm      = line_valid.exists(32'h0000_6030);
      mem_ack   = mem_req;
      mem_rdata = mem_read(mem_addr);
      @(negedge clk);
      if (fill_we) fills_seen++;
      @(posedge clk); #1;
      cyc++;
    end
    check("mid fills seen", fills_seen, 2);
    mem_ack = 1'b0;
    check("mid req before rst", mem_req, 1);
    check("mid addr before rst", mem_addr, 32'h0000_6038);
    #2 rst_n = 1'b0;
    #1;
    check("mid req after rst", mem_req,     0);
    check("mid tag after rst", fill_tag_we, 0);
    check("mid fill after rst", fill_we,    0);
    repeat (2) begin
      @(negedge clk);
      check("mid tag in rst", fill_tag_we, 0);
    end
    rst_n    = 1'b1;
    memreadm = 1'b0;
    @(posedge clk); #1;
    check("mid line invalid", line_valid.exists(32'h0000_6030), 0);
    run_op("mid refill", 0, 32'h0000_6034, 32'h0, 0, 6, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
